// File: rtl/imuldiv_int_mul_pipelined_param.sv
// Elastic, fully pipelined W x W -> 2W signed/unsigned multiplier with STAGES-cycle latency.
// Optional completed-response counter port mulresp_count: define IMULDIV_MUL_COUNT_EN.
module imuldiv_int_mul_pipelined_param #(
   parameter int W              = 32,
   parameter int STAGES         = 4,
   parameter int SIGNED_DEFAULT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [W-1:0]     mulreq_msg_a,
   input  logic [W-1:0]     mulreq_msg_b,
   input  logic             mulreq_msg_sign,
   input  logic             mulreq_val,
   output logic             mulreq_rdy,
   output logic [2*W-1:0]   mulresp_msg_result,
   output logic             mulresp_val,
   input  logic             mulresp_rdy
`ifdef IMULDIV_MUL_COUNT_EN
   ,
   output logic [31:0]      mulresp_count
`endif
);

   localparam int CHUNK = W / STAGES;

   if ((W < 8) || ((W % 2) != 0) || (STAGES < 1) || (STAGES > 8) || ((W % STAGES) != 0) ||
       ((SIGNED_DEFAULT != 0) && (SIGNED_DEFAULT != 1))) begin : g_bad_param
      $error("imuldiv_int_mul_pipelined_param: illegal parameter combination");
   end

   // Sum of the CHUNK partial products of |B| bits [k*CHUNK +: CHUNK] times |A|.
   function automatic logic [2*W-1:0] pp_chunk(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input int unsigned k);
      logic [2*W-1:0] sh_a;
      logic [W-1:0]   sh_b;
      logic [2*W-1:0] sum;
      sh_a = {{W{1'b0}}, a} << (k * CHUNK);
      sh_b = b >> (k * CHUNK);
      sum  = '0;
      for (int j = 0; j < CHUNK; j++) begin
         if (sh_b[0]) begin
            sum = sum + sh_a;
         end
         sh_a = sh_a << 1'b1;
         sh_b = sh_b >> 1'b1;
      end
      return sum;
   endfunction

   logic [STAGES-1:0] val_s;
   logic [STAGES-1:0] can_load_s;
   logic [STAGES-1:0] leave_s;

   // A stage can load if it or any stage downstream of it is empty, or the sink takes the head.
   for (genvar k = 0; k < STAGES; k++) begin : g_flow
      assign can_load_s[k] = mulresp_rdy | ~(&val_s[STAGES-1:k]);
      if (k == STAGES - 1) begin : g_last
         assign leave_s[k] = val_s[k] & mulresp_rdy;
      end else begin : g_mid
         assign leave_s[k] = val_s[k] & can_load_s[k+1];
      end
   end

   assign mulreq_rdy = reset & can_load_s[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam bit IS_LAST = (k == STAGES - 1);
      logic [W-1:0]   in_a_s;
      logic [W-1:0]   in_b_s;
      logic           in_neg_s;
      logic           load_s;
      logic [2*W-1:0] in_acc_s;
      logic [2*W-1:0] sum_s;
      logic           val_q;
      logic           val_d;
      logic [2*W-1:0] acc_q;
      logic [2*W-1:0] acc_d;

      if (k == 0) begin : g_src
         // Operands enter as magnitudes; the product sign travels alongside them.
         always_comb begin
            load_s   = mulreq_val & mulreq_rdy;
            in_acc_s = '0;
            in_neg_s = mulreq_msg_sign & (mulreq_msg_a[W-1] ^ mulreq_msg_b[W-1]);
            if (mulreq_msg_sign & mulreq_msg_a[W-1]) begin
               in_a_s = -mulreq_msg_a;
            end else begin
               in_a_s = mulreq_msg_a;
            end
            if (mulreq_msg_sign & mulreq_msg_b[W-1]) begin
               in_b_s = -mulreq_msg_b;
            end else begin
               in_b_s = mulreq_msg_b;
            end
         end
      end else begin : g_pipe
         // Inputs come from the previous stage as it hands its entry forward.
         always_comb begin
            load_s   = leave_s[k-1];
            in_a_s   = g_st[k-1].g_fwd.a_q;
            in_b_s   = g_st[k-1].g_fwd.b_q;
            in_neg_s = g_st[k-1].g_fwd.neg_q;
            in_acc_s = g_st[k-1].acc_q;
         end
      end

      // Accumulate this stage's partial products; the last stage restores the sign.
      always_comb begin
         sum_s = in_acc_s + pp_chunk(in_a_s, in_b_s, k);
         if (IS_LAST && in_neg_s) begin
            sum_s = -sum_s;
         end else begin
            sum_s = sum_s;
         end
      end

      // Stage occupancy and accumulator next state.
      always_comb begin
         if (load_s) begin
            val_d = 1'b1;
            acc_d = sum_s;
         end else begin
            val_d = val_q & ~leave_s[k];
            acc_d = acc_q;
         end
      end

      // Stage occupancy and accumulator registers.
      always_ff @(posedge clk) begin
         if (!reset) begin
            val_q <= 1'b0;
            acc_q <= '0;
         end else begin
            val_q <= val_d;
            acc_q <= acc_d;
         end
      end

      assign val_s[k] = val_q;

      if (k < STAGES - 1) begin : g_fwd
         logic [W-1:0] a_q;
         logic [W-1:0] a_d;
         logic [W-1:0] b_q;
         logic [W-1:0] b_d;
         logic         neg_q;
         logic         neg_d;

         // Operand magnitudes and sign forwarded to the next stage.
         always_comb begin
            if (load_s) begin
               a_d   = in_a_s;
               b_d   = in_b_s;
               neg_d = in_neg_s;
            end else begin
               a_d   = a_q;
               b_d   = b_q;
               neg_d = neg_q;
            end
         end

         // Operand forwarding registers.
         always_ff @(posedge clk) begin
            if (!reset) begin
               a_q   <= '0;
               b_q   <= '0;
               neg_q <= 1'b0;
            end else begin
               a_q   <= a_d;
               b_q   <= b_d;
               neg_q <= neg_d;
            end
         end
      end
   end

   assign mulresp_val        = val_s[STAGES-1];
   assign mulresp_msg_result = g_st[STAGES-1].acc_q;

`ifdef IMULDIV_MUL_COUNT_EN
   logic [31:0] count_q;
   logic [31:0] count_d;

   // Completed-response count, wrapping at 2^32.
   always_comb begin
      if (mulresp_val & mulresp_rdy) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Completed-response count register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign mulresp_count = count_q;
`endif

endmodule
